// File: rtl/ingress_vc_shaper.sv
// Per-VC holding queues feeding the QoS block one word per clock, round-robin
// among VCs whose QoS flow-control state allows sending.
module ingress_vc_shaper #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int DATA_BITS      = 4,
    parameter int HOLD_DEPTH     = 2,
    parameter int VC_BITS        = $clog2(QUEUE_QUANTITY)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enb,
    input  logic                        in_valid,
    input  logic [VC_BITS-1:0]          in_vc,
    input  logic [DATA_BITS-1:0]        in_data,
    output logic                        in_ready,
    input  logic [QUEUE_QUANTITY-1:0]   pausa,
    input  logic [QUEUE_QUANTITY-1:0]   continuar,
    input  logic [QUEUE_QUANTITY-1:0]   error_full,
    output logic [VC_BITS-1:0]          vc_id,
    output logic [DATA_BITS-1:0]        data_word,
    output logic                        out_valid,
    output logic [2*QUEUE_QUANTITY-1:0] vc_state,
    output logic [7:0]                  drop_count
);
    localparam int PTR_BITS = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
    localparam int CNT_BITS = $clog2(HOLD_DEPTH) + 1;
    localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(HOLD_DEPTH);

    typedef enum logic [1:0] {RUN = 2'b00, PAUSED = 2'b01, ERROR = 2'b10} vc_st_e;

    logic [QUEUE_QUANTITY-1:0][1:0]           st;
    logic [QUEUE_QUANTITY-1:0][CNT_BITS-1:0]  occ;
    logic [QUEUE_QUANTITY-1:0][DATA_BITS-1:0] head;
    logic [QUEUE_QUANTITY-1:0]                elig;
    logic [QUEUE_QUANTITY-1:0]                push;
    logic [QUEUE_QUANTITY-1:0]                pop;
    logic [VC_BITS-1:0]                       ptr;
    logic [VC_BITS-1:0]                       grant;
    logic [VC_BITS-1:0]                       idx;
    int                                       sel;
    logic                                     grant_any;
    logic                                     accept;
    logic                                     in_err;
    logic                                     out_valid_q;

    // A VC in ERROR always accepts so upstream never stalls on it; the word is dropped.
    assign in_err   = (st[in_vc] == ERROR);
    assign in_ready = !rst && enb && (in_err || occ[in_vc] != FULL);
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < QUEUE_QUANTITY; i++) begin : g_vc
        logic [1:0]           st_q;
        logic [DATA_BITS-1:0] mem [HOLD_DEPTH];
        logic [PTR_BITS-1:0]  wp;
        logic [PTR_BITS-1:0]  rp;
        logic [CNT_BITS-1:0]  n;

        assign push[i] = accept && !in_err && (in_vc == VC_BITS'(i));
        assign pop[i]  = grant_any && (grant == VC_BITS'(i));
        assign elig[i] = (st_q != PAUSED) && (st_q != ERROR) && (n != '0);
        assign st[i]   = st_q;
        assign occ[i]  = n;
        assign head[i] = mem[rp];

        always_ff @(posedge clk) begin
            if (rst) begin
                st_q <= RUN;
            end else if (enb) begin
                if (error_full[i]) begin
                    st_q <= ERROR;
                end else begin
                    case (st_q)
                        PAUSED:  if (continuar[i] && !pausa[i]) st_q <= RUN;
                        ERROR:   if (continuar[i]) st_q <= RUN;
                        default: if (pausa[i]) st_q <= PAUSED;
                    endcase
                end
            end
        end

        // Flush on error wins over a same-edge push or pop.
        always_ff @(posedge clk) begin
            if (rst) begin
                wp <= '0;
                rp <= '0;
                n  <= '0;
            end else if (enb) begin
                if (error_full[i]) begin
                    wp <= '0;
                    rp <= '0;
                    n  <= '0;
                end else begin
                    if (push[i]) wp <= wp + 1'b1;
                    if (pop[i])  rp <= rp + 1'b1;
                    n <= n + CNT_BITS'(push[i]) - CNT_BITS'(pop[i]);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (enb && push[i] && !error_full[i]) mem[wp] <= in_data;
        end
    end

    always_comb begin
        grant_any = 1'b0;
        grant     = '0;
        idx       = '0;
        sel       = 0;
        for (int k = 0; k < QUEUE_QUANTITY; k++) begin
            sel = (int'(ptr) + k) % QUEUE_QUANTITY;
            idx = VC_BITS'(sel);
            if (!grant_any && elig[idx]) begin
                grant_any = 1'b1;
                grant     = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            vc_id       <= '0;
            data_word   <= '0;
            ptr         <= '0;
            drop_count  <= '0;
        end else if (enb) begin
            out_valid_q <= grant_any;
            if (grant_any) begin
                vc_id     <= grant;
                data_word <= head[grant];
                ptr       <= (int'(grant) == QUEUE_QUANTITY - 1) ? '0 : grant + 1'b1;
            end
            if (accept && in_err && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

    assign out_valid = out_valid_q && enb;
    assign vc_state  = st;

endmodule

// File: tb/tb_ingress_vc_shaper.sv
// Randomized and directed bench for ingress_vc_shaper against a queue-based
// behavioural model of the per-VC flow control and round-robin issue.
module tb_ingress_vc_shaper;
    localparam int QQ = 4;
    localparam int HD = 2;

    logic       clk = 1'b0;
    logic       rst, enb, in_valid, in_ready, out_valid;
    logic [1:0] in_vc, vc_id;
    logic [3:0] in_data, data_word, pausa, continuar, error_full;
    logic [7:0] vc_state, drop_count;

    always #5 clk = ~clk;

    ingress_vc_shaper #(.QUEUE_QUANTITY(QQ), .DATA_BITS(4), .HOLD_DEPTH(HD)) dut (
        .clk(clk), .rst(rst), .enb(enb), .in_valid(in_valid), .in_vc(in_vc),
        .in_data(in_data), .in_ready(in_ready), .pausa(pausa), .continuar(continuar),
        .error_full(error_full), .vc_id(vc_id), .data_word(data_word),
        .out_valid(out_valid), .vc_state(vc_state), .drop_count(drop_count)
    );

    int tests = 0;
    int fails = 0;

    // Model: state 0=RUN 1=PAUSED 2=ERROR, one data queue per VC.
    int         m_st [QQ];
    logic [3:0] mq [QQ][$];
    int         m_ptr, m_drop;
    logic       m_ovq;
    logic [1:0] m_vc;
    logic [3:0] m_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < QQ; i++) begin
            m_st[i] = 0;
            mq[i].delete();
        end
        m_ptr = 0; m_drop = 0; m_ovq = 1'b0; m_vc = '0; m_data = '0;
    endtask

    function automatic bit model_ready();
        return !rst && enb && (m_st[in_vc] == 2 || mq[in_vc].size() < HD);
    endfunction

    task automatic set_in(input bit v, input int vc, input int d);
        in_valid = v;
        in_vc    = vc[1:0];
        in_data  = d[3:0];
    endtask

    task automatic set_fc(input logic [3:0] p, input logic [3:0] c, input logic [3:0] e);
        pausa = p; continuar = c; error_full = e;
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after.
    task automatic cyc();
        bit         rdy;
        int         w;
        logic [7:0] ev;
        #1;
        rdy = model_ready();
        chk("in_ready", in_ready, rdy);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (enb) begin
            w = -1;
            for (int k = 0; k < QQ; k++) begin
                int v;
                v = (m_ptr + k) % QQ;
                if (w < 0 && m_st[v] == 0 && mq[v].size() > 0) w = v;
            end
            m_ovq = (w >= 0);
            if (w >= 0) begin
                m_vc   = w[1:0];
                m_data = mq[w].pop_front();
                m_ptr  = (w + 1) % QQ;
            end
            if (in_valid && rdy) begin
                if (m_st[in_vc] == 2) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    mq[in_vc].push_back(in_data);
                end
            end
            for (int i = 0; i < QQ; i++) begin
                if (error_full[i]) begin
                    m_st[i] = 2;
                    mq[i].delete();
                end else if (m_st[i] == 0 && pausa[i]) m_st[i] = 1;
                else if (m_st[i] == 1 && continuar[i] && !pausa[i]) m_st[i] = 0;
                else if (m_st[i] == 2 && continuar[i]) m_st[i] = 0;
            end
        end
        #1;
        ev = '0;
        for (int i = 0; i < QQ; i++) ev[2*i +: 2] = m_st[i][1:0];
        chk("out_valid", out_valid, m_ovq & enb);
        chk("vc_id", vc_id, m_vc);
        chk("data_word", data_word, m_data);
        chk("vc_state", vc_state, ev);
        chk("drop_count", drop_count, m_drop);
    endtask

    initial begin
        logic [3:0] p, c, e;
        model_reset();
        rst = 1'b1; enb = 1'b1;
        set_in(1, 1, 5); set_fc(0, 0, 0);

        // Reset with a word presented
        repeat (2) begin
            #1 chk("rst_in_ready", in_ready, 0);
            cyc();
        end
        chk("rst_out_valid", out_valid, 0);
        chk("rst_vc_state", vc_state, 8'h00);
        chk("rst_drop", drop_count, 0);
        rst = 1'b0; set_in(0, 0, 0);
        repeat (3) begin
            cyc();
            chk("rst_idle", out_valid, 0);
        end

        // Single word latency
        set_in(1, 2, 4'hA); cyc();
        set_in(0, 0, 0); cyc();
        chk("lat_valid", out_valid, 1);
        chk("lat_vc", vc_id, 2);
        chk("lat_data", data_word, 4'hA);
        cyc();
        chk("lat_gap", out_valid, 0);

        // Round-robin over 8 preloaded words
        rst = 1'b1; cyc(); rst = 1'b0;
        set_fc(4'hF, 0, 0); cyc(); set_fc(0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            set_in(1, j / 2, (j / 2) * 2 + j % 2);
            cyc();
        end
        set_in(0, 0, 0); set_fc(0, 4'hF, 0); cyc(); set_fc(0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            cyc();
            chk("rr_valid", out_valid, 1);
            chk("rr_vc", vc_id, j % 4);
            chk("rr_data", data_word, (j % 4) * 2 + j / 4);
        end
        cyc();
        chk("rr_end", out_valid, 0);

        // Pause VC1 and VC3, resume VC3 then VC1
        set_fc(4'b1010, 0, 0); cyc(); set_fc(0, 0, 0);
        set_in(1, 1, 8);  cyc();
        set_in(1, 1, 9);  cyc();
        set_in(1, 3, 12); cyc();
        set_in(1, 3, 13); cyc();
        set_in(1, 1, 14);
        #1 chk("pause_full_rdy", in_ready, 0);
        chk("pause_state", vc_state[3:2], 2'b01);
        cyc();
        set_in(0, 0, 0); set_fc(0, 4'b1000, 0); cyc(); set_fc(0, 0, 0);
        for (int j = 0; j < 2; j++) begin
            cyc();
            chk("ps_vc3_valid", out_valid, 1);
            chk("ps_vc3_id", vc_id, 3);
            chk("ps_vc3_data", data_word, 12 + j);
        end
        cyc();
        chk("ps_hold", out_valid, 0);
        chk("ps_vc1_paused", vc_state[3:2], 2'b01);
        set_fc(0, 4'b0010, 0); cyc(); set_fc(0, 0, 0);
        for (int j = 0; j < 2; j++) begin
            cyc();
            chk("rs_vc1_valid", out_valid, 1);
            chk("rs_vc1_id", vc_id, 1);
            chk("rs_vc1_data", data_word, 8 + j);
        end

        // Error: flush, drop, recover
        set_fc(4'b0001, 0, 0); cyc(); set_fc(0, 0, 0);
        set_in(1, 0, 3); cyc();
        set_in(1, 0, 4); cyc();
        set_in(0, 0, 0); set_fc(0, 0, 4'b0001); cyc(); set_fc(0, 0, 0);
        chk("err_state", vc_state[1:0], 2'b10);
        for (int j = 0; j < 3; j++) begin
            set_in(1, 0, j);
            #1 chk("err_rdy", in_ready, 1);
            cyc();
            chk("err_no_out", out_valid, 0);
        end
        set_in(0, 0, 0);
        chk("err_drop", drop_count, 3);
        set_fc(0, 4'b0001, 0); cyc(); set_fc(0, 0, 0);
        chk("err_run", vc_state[1:0], 2'b00);
        repeat (2) begin
            cyc();
            chk("err_flushed", out_valid, 0);
        end

        // Simultaneous error and pause
        set_fc(4'b0100, 0, 4'b0100); cyc(); set_fc(0, 0, 0);
        chk("sim_err", vc_state[5:4], 2'b10);
        set_fc(0, 4'b0100, 0); cyc(); set_fc(0, 0, 0);

        // Full VC0 with pop, then push and pop on the same edge
        set_fc(4'b0001, 0, 0); cyc(); set_fc(0, 0, 0);
        set_in(1, 0, 1); cyc();
        set_in(1, 0, 2); cyc();
        set_in(0, 0, 0); set_fc(0, 4'b0001, 0); cyc(); set_fc(0, 0, 0);
        set_in(1, 0, 3);
        #1 chk("pp_full_rdy", in_ready, 0);
        cyc();
        chk("pp_d1", data_word, 1);
        chk("pp_v1", out_valid, 1);
        #1 chk("pp_rdy", in_ready, 1);
        cyc();
        chk("pp_d2", data_word, 2);
        set_in(0, 0, 0); cyc();
        chk("pp_d3", data_word, 3);
        chk("pp_v3", out_valid, 1);
        cyc();
        chk("pp_empty", out_valid, 0);

        // Enable low freezes everything
        set_in(1, 2, 5); cyc();
        enb = 1'b0; set_fc(4'hF, 4'hF, 4'hF);
        repeat (3) begin
            cyc();
            chk("enb_ov", out_valid, 0);
        end
        chk("enb_state", vc_state, 8'h00);
        enb = 1'b1; set_fc(0, 0, 0); set_in(0, 0, 0); cyc();
        chk("enb_resume_v", out_valid, 1);
        chk("enb_resume_vc", vc_id, 2);
        chk("enb_resume_d", data_word, 5);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            enb = ($urandom_range(0, 9) != 0);
            set_in($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 15));
            p = '0; c = '0; e = '0;
            for (int i = 0; i < QQ; i++) begin
                p[i] = ($urandom_range(0, 9) == 0);
                c[i] = ($urandom_range(0, 9) < 2);
                e[i] = ($urandom_range(0, 49) == 0);
            end
            set_fc(p, c, e);
            cyc();
        end

        // Drop counter saturation
        rst = 1'b1; enb = 1'b1; set_in(0, 0, 0); set_fc(0, 0, 0); cyc(); rst = 1'b0;
        set_fc(0, 0, 4'b0010); cyc(); set_fc(0, 0, 0);
        set_in(1, 1, 7);
        repeat (260) cyc();
        chk("sat_drop", drop_count, 255);
        set_in(0, 0, 0); cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
